// File: rtl/fibonacci_lanes_if.sv
// Output beat bus of fibonacci_lanes: valid/ready handshake carrying LANES terms per beat.
interface fibonacci_lanes_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
) ();
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [LANES*WIDTH-1:0]   num;

  modport master (output out_valid, output num, output out_last, input out_ready);
  modport slave  (input out_valid, input num, input out_last, output out_ready);
endinterface

// File: rtl/fibonacci_lanes.sv
// fibonacci_lanes: emits LANES consecutive Fibonacci terms per beat for a
// programmable number of beats, with sticky wrap reporting on ovf.
// Optional build macro FIB_OVERFLOW_STOP_EN: end the run on the last beat
// that contains no wrapped term instead of wrapping modulo 2^WIDTH.
module fibonacci_lanes #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  seed0,
  input  logic [WIDTH-1:0]  seed1,
  input  logic [LEN_W-1:0]  len,
  fibonacci_lanes_if.master ob,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NW = LANES * WIDTH;
`ifdef FIB_OVERFLOW_STOP_EN
  // Also look one beat ahead so the last wrap-free beat can be flagged.
  localparam int unsigned NT = (2 * LANES > LANES + 2) ? 2 * LANES : LANES + 2;
`else
  localparam int unsigned NT = LANES + 2;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  pa_q, pb_q;   // first two terms of the next beat
  logic              fa_q, fb_q;   // those terms are (or derive from) a wrap
  logic [LEN_W-1:0]  rem_q;        // beats left after the one presented
  logic [NW-1:0]     num_q;
  logic              valid_q, last_q, ovf_q, done_q;

  logic [WIDTH-1:0]  t [NT];
  logic [NT-1:0]     cw;
  logic [WIDTH:0]    s;
  logic [NW-1:0]     num_d;
  logic              beat_wrap;
  logic [LEN_W-1:0]  rem_src, rem_d;
  logic              more, last_d, ovf_d;
`ifdef FIB_OVERFLOW_STOP_EN
  logic              next_wrap;
`endif

  // Adder chain from seeds (IDLE) or the stored pair (RUN), plus beat control.
  always_comb begin
    s         = '0;
    num_d     = '0;
    beat_wrap = 1'b0;
    cw        = '0;
    for (int unsigned k = 0; k < NT; k++) t[k] = '0;
    if (state_q == IDLE) begin
      t[0] = seed0;
      t[1] = seed1;
    end else begin
      t[0]  = pa_q;
      t[1]  = pb_q;
      cw[0] = fa_q;
      cw[1] = fb_q;
    end
    for (int unsigned k = 2; k < NT; k++) begin
      s     = {1'b0, t[k-1]} + {1'b0, t[k-2]};
      t[k]  = s[WIDTH-1:0];
      cw[k] = s[WIDTH] | cw[k-1] | cw[k-2];
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      num_d[k*WIDTH +: WIDTH] = t[k];
      beat_wrap = beat_wrap | cw[k];
    end
    rem_src = (state_q == IDLE) ? len : rem_q;
    rem_d   = rem_src - LEN_W'(1);
    more    = (rem_src != LEN_W'(1));
`ifdef FIB_OVERFLOW_STOP_EN
    next_wrap = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) next_wrap = next_wrap | cw[LANES+k];
    last_d = !more | next_wrap;
    ovf_d  = next_wrap & more;
`else
    last_d = !more;
    ovf_d  = beat_wrap;
`endif
  end

  // Run control FSM with registered beat, flags and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pa_q    <= '0;
      pb_q    <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      rem_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_q <= 1'b1;
              ovf_q  <= 1'b0;
            end
`ifdef FIB_OVERFLOW_STOP_EN
            else if (beat_wrap) begin
              done_q <= 1'b1;
              ovf_q  <= 1'b1;
            end
`endif
            else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              num_q   <= num_d;
              last_q  <= last_d;
              ovf_q   <= ovf_d;
              pa_q    <= t[LANES];
              pb_q    <= t[LANES+1];
              fa_q    <= cw[LANES];
              fb_q    <= cw[LANES+1];
              rem_q   <= rem_d;
            end
          end
        end
        RUN: begin
          if (valid_q && ob.out_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              num_q  <= num_d;
              last_q <= last_d;
              ovf_q  <= ovf_q | ovf_d;
              pa_q   <= t[LANES];
              pb_q   <= t[LANES+1];
              fa_q   <= cw[LANES];
              fb_q   <= cw[LANES+1];
              rem_q  <= rem_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ob.out_valid = valid_q;
  assign ob.num       = num_q;
  assign ob.out_last  = last_q;
  assign ovf          = ovf_q;
  assign done         = done_q;
  assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_fibonacci_lanes.sv
// Self-checking bench for fibonacci_lanes (WIDTH=16, LANES=2) against a
// term-list reference model; honours FIB_OVERFLOW_STOP_EN when defined.
module tb_fibonacci_lanes;
  localparam int unsigned W  = 16;
  localparam int unsigned L  = 2;
  localparam int unsigned LW = 16;
`ifdef FIB_OVERFLOW_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] seed0, seed1;
  logic [LW-1:0] len;
  logic ovf, busy, done;

  fibonacci_lanes_if #(.WIDTH(W), .LANES(L)) ifc ();

  fibonacci_lanes #(.WIDTH(W), .LANES(L), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .len(len), .ob(ifc.master), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [L*W-1:0] got_num[$], exp_num[$];
  bit got_last[$], exp_last[$], got_ovf[$], exp_ovf[$];
  bit exp_done_ovf, done_seen, done_ovf_got, timed_out;
  int done_cyc, last_hs, first_valid, stall_err;

  // Reference: list the terms with plain arithmetic, then cut into beats.
  task automatic model(input logic [W-1:0] s0, input logic [W-1:0] s1, input int n);
    longint t[];
    longint sm;
    int tot, fw, hi;
    logic [L*W-1:0] p;
    bit lst, ov;
    exp_num.delete(); exp_last.delete(); exp_ovf.delete();
    exp_done_ovf = 1'b0;
    tot = n * L + 2 * L + 2;
    t = new[tot];
    t[0] = longint'(s0);
    t[1] = longint'(s1);
    fw = tot + 100;
    for (int k = 2; k < tot; k++) begin
      sm = t[k-1] + t[k-2];
      if (sm >= (64'sd1 <<< W) && fw > k) fw = k;
      t[k] = sm % (64'sd1 <<< W);
    end
    for (int b = 0; b < n; b++) begin
      hi = b * L + L - 1;
      if (STOP && fw <= hi) begin
        if (b == 0) exp_done_ovf = 1'b1;
        break;
      end
      for (int k = 0; k < L; k++) p[k*W +: W] = W'(t[b*L+k]);
      lst = (b == n - 1);
      ov  = (fw <= hi);
      if (STOP && !lst && fw <= hi + L) begin
        lst = 1'b1;
        ov  = 1'b1;
      end
      exp_num.push_back(p); exp_last.push_back(lst); exp_ovf.push_back(ov);
      exp_done_ovf = ov;
      if (lst) break;
    end
  endtask

  // Drive one run and record every accepted beat, the done pulse and stalls.
  task automatic run_dut(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [LW-1:0] n,
                         input int pct, input bit hammer, input bit skip_start, input bit chain,
                         input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [LW-1:0] cn);
    logic [L*W-1:0] hold_num;
    bit hold_last, hold_ovf, stalled;
    got_num.delete(); got_last.delete(); got_ovf.delete();
    done_seen = 0; done_ovf_got = 0; timed_out = 0;
    done_cyc = -1; last_hs = -1; first_valid = -1; stall_err = 0;
    hold_num = '0; hold_last = 0; hold_ovf = 0; stalled = 0;
    if (!skip_start) begin
      start = 1'b1; seed0 = s0; seed1 = s1; len = n;
    end
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled && (ifc.out_valid !== 1'b1 || ifc.num !== hold_num ||
                      ifc.out_last !== hold_last || ovf !== hold_ovf)) stall_err++;
      if (done === 1'b1) begin
        done_seen = 1; done_ovf_got = ovf; done_cyc = cyc;
        if (chain) begin
          start = 1'b1; seed0 = c0; seed1 = c1; len = cn;
        end else start = 1'b0;
        return;
      end
      ifc.out_ready = ($urandom_range(99) < pct);
      if (hammer) begin
        start = 1'b1; seed0 = W'($urandom); seed1 = W'($urandom); len = LW'($urandom_range(1, 5));
      end
      stalled = 0;
      if (ifc.out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (ifc.out_ready) begin
          got_num.push_back(ifc.num); got_last.push_back(ifc.out_last); got_ovf.push_back(ovf);
          last_hs = cyc;
        end else begin
          stalled = 1; hold_num = ifc.num; hold_last = ifc.out_last; hold_ovf = ovf;
        end
      end
      @(negedge clk);
    end
    timed_out = 1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; len = '0; ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifc.out_valid); end
    checks++; if (ifc.num !== '0) begin errors++; $display("FAIL reset_num got=%h exp=0", ifc.num); end
    checks++; if ({ifc.out_last, ovf, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ifc.out_last, ovf, busy, done}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [L*W-1:0] b5;
    b5 = {16'd55, 16'd34};
    model(16'd1, 16'd1, 5);
    run_dut(16'd1, 16'd1, 16'd5, 100, 0, 0, 0, '0, '0, '0);
    checks++; if (timed_out || !done_seen) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_seen); end
    checks++; if (got_num.size() != exp_num.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_num.size(), exp_num.size()); end
    for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
      checks++;
      if (got_num[i] !== exp_num[i] || got_last[i] !== exp_last[i] || got_ovf[i] !== exp_ovf[i]) begin
        errors++; $display("FAIL basic_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_num[i], got_last[i], got_ovf[i], exp_num[i], exp_last[i], exp_ovf[i]);
      end
    end
    if (got_num.size() == 5) begin
      checks++; if (got_num[4] !== b5 || got_last[4] !== 1'b1) begin errors++; $display("FAIL basic_beat5 got=%h/%b exp=%h/1", got_num[4], got_last[4], b5); end
    end
    checks++; if (first_valid != 0 || last_hs != 4) begin errors++; $display("FAIL basic_timing got=%0d,%0d exp=0,4", first_valid, last_hs); end
    checks++; if (done_cyc != last_hs + 1 || done_ovf_got !== 1'b0) begin errors++; $display("FAIL basic_done_lat got=%0d/%b exp=%0d/0", done_cyc, done_ovf_got, last_hs + 1); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] s0, s1;
    int n;
    for (int it = 0; it < 12; it++) begin
      s0 = (it % 2 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      s1 = (it % 2 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      n  = $urandom_range(1, 12);
      model(s0, s1, n);
      run_dut(s0, s1, LW'(n), 45, 0, 0, 0, '0, '0, '0);
      checks++; if (timed_out || !done_seen) begin errors++; $display("FAIL bp_done it=%0d got=%0d exp=1", it, done_seen); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable it=%0d got=%0d exp=0", it, stall_err); end
      checks++; if (got_num.size() != exp_num.size() || done_ovf_got !== exp_done_ovf) begin
        errors++; $display("FAIL bp_count it=%0d got=%0d/%b exp=%0d/%b", it, got_num.size(), done_ovf_got, exp_num.size(), exp_done_ovf);
      end
      for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
        checks++;
        if (got_num[i] !== exp_num[i] || got_last[i] !== exp_last[i] || got_ovf[i] !== exp_ovf[i]) begin
          errors++; $display("FAIL bp_beat it=%0d i=%0d got=%h/%b/%b exp=%h/%b/%b", it, i, got_num[i], got_last[i], got_ovf[i], exp_num[i], exp_last[i], exp_ovf[i]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [L*W-1:0] b12, b13;
    b12 = {16'd46368, 16'd28657};
    b13 = {16'd55857, 16'd9489};
    model(16'd1, 16'd1, 20);
    run_dut(16'd1, 16'd1, 16'd20, 100, 0, 0, 0, '0, '0, '0);
    checks++; if (timed_out || got_num.size() != exp_num.size()) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", got_num.size(), exp_num.size()); end
    for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
      checks++;
      if (got_num[i] !== exp_num[i] || got_last[i] !== exp_last[i] || got_ovf[i] !== exp_ovf[i]) begin
        errors++; $display("FAIL wrap_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_num[i], got_last[i], got_ovf[i], exp_num[i], exp_last[i], exp_ovf[i]);
      end
    end
`ifdef FIB_OVERFLOW_STOP_EN
    checks++; if (got_num.size() != 12) begin errors++; $display("FAIL wrap_stop_len got=%0d exp=12", got_num.size()); end
    if (got_num.size() == 12) begin
      checks++; if (got_num[11] !== b12 || got_last[11] !== 1'b1 || got_ovf[11] !== 1'b1) begin errors++; $display("FAIL wrap_stop_b12 got=%h/%b/%b exp=%h/1/1", got_num[11], got_last[11], got_ovf[11], b12); end
    end
    checks++; if (!done_seen || done_ovf_got !== 1'b1) begin errors++; $display("FAIL wrap_stop_done got=%b/%b exp=1/1", done_seen, done_ovf_got); end
`else
    if (got_num.size() == 20) begin
      checks++; if (got_num[11] !== b12 || got_ovf[11] !== 1'b0) begin errors++; $display("FAIL wrap_b12 got=%h/%b exp=%h/0", got_num[11], got_ovf[11], b12); end
      checks++; if (got_num[12] !== b13 || got_ovf[12] !== 1'b1) begin errors++; $display("FAIL wrap_b13 got=%h/%b exp=%h/1", got_num[12], got_ovf[12], b13); end
      checks++; if (got_ovf[19] !== 1'b1 || done_ovf_got !== 1'b1) begin errors++; $display("FAIL wrap_sticky got=%b/%b exp=1/1", got_ovf[19], done_ovf_got); end
    end
`endif
  endtask

  task automatic test_len0;
    run_dut(W'($urandom), W'($urandom), 16'd0, 100, 0, 0, 0, '0, '0, '0);
    checks++; if (first_valid != -1 || got_num.size() != 0) begin errors++; $display("FAIL len0_novalid got=%0d exp=-1", first_valid); end
    checks++; if (!done_seen || done_cyc != 0) begin errors++; $display("FAIL len0_done got=%0d exp=0", done_cyc); end
    checks++; if (done_ovf_got !== 1'b0) begin errors++; $display("FAIL len0_ovf_clear got=%b exp=0", done_ovf_got); end
  endtask

  task automatic test_start_busy;
    logic [W-1:0] s0, s1;
    int n;
    for (int it = 0; it < 3; it++) begin
      s0 = W'($urandom_range(0, 100)); s1 = W'($urandom_range(0, 100)); n = $urandom_range(3, 8);
      model(s0, s1, n);
      run_dut(s0, s1, LW'(n), 70, 1, 0, 0, '0, '0, '0);
      checks++; if (timed_out || got_num.size() != exp_num.size()) begin errors++; $display("FAIL busy_count it=%0d got=%0d exp=%0d", it, got_num.size(), exp_num.size()); end
      for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
        checks++;
        if (got_num[i] !== exp_num[i] || got_last[i] !== exp_last[i]) begin
          errors++; $display("FAIL busy_beat it=%0d i=%0d got=%h/%b exp=%h/%b", it, i, got_num[i], got_last[i], exp_num[i], exp_last[i]);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] c0, c1;
    c0 = W'($urandom_range(0, 200)); c1 = W'($urandom_range(0, 200));
    run_dut(16'd2, 16'd3, 16'd3, 100, 0, 0, 1, c0, c1, 16'd4);
    checks++; if (!done_seen || got_num.size() != 3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", got_num.size()); end
    model(c0, c1, 4);
    run_dut('0, '0, '0, 100, 0, 1, 0, '0, '0, '0);
    checks++; if (first_valid != 0) begin errors++; $display("FAIL b2b_latency got=%0d exp=0", first_valid); end
    checks++; if (got_num.size() != exp_num.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_num.size(), exp_num.size()); end
    for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
      checks++;
      if (got_num[i] !== exp_num[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, got_num[i], got_last[i], exp_num[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int hs;
    bit hit;
    logic [W-1:0] s0, s1;
    hs = 0; hit = 0;
    start = 1'b1; seed0 = 16'd1; seed1 = 16'd1; len = 16'd10; ifc.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      if (ifc.out_valid === 1'b1 && hs == 2) begin
        rst = 1'b1; hit = 1;
      end else if (ifc.out_valid === 1'b1) hs++;
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got=%0d exp=2", hs); end
    checks++; if ({ifc.out_valid, ifc.out_last, ovf, busy, done} !== 5'b0 || ifc.num !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%h exp=00000/0", {ifc.out_valid, ifc.out_last, ovf, busy, done}, ifc.num);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got=%b/%b exp=0/0", done, busy); end
    s0 = W'($urandom_range(0, 300)); s1 = W'($urandom_range(0, 300));
    run_dut(s0, s1, 16'd2, 100, 0, 0, 0, '0, '0, '0);
    checks++; if (got_num.size() < 1 || got_num[0] !== {s1, s0}) begin
      errors++; $display("FAIL rstmid_restart got=%h exp=%h", (got_num.size() > 0) ? got_num[0] : '0, {s1, s0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len0();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
